// File: rtl/k_dsp_pkg.sv
// Shared types and constants for the K_DSP pixel sequencer: FSM states,
// channel encodings and the channel-advance helper.
package k_dsp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_POP,
    ST_ALU,
    ST_DRAIN,
    ST_NEXT,
    ST_DONE
  } pixseq_state_t;

  localparam logic [1:0] CH_BLUE  = 2'd0;
  localparam logic [1:0] CH_GREEN = 2'd1;
  localparam logic [1:0] CH_RED   = 2'd2;

  localparam int unsigned SAMPLES_PER_PIXEL = 3;

  // Channel order is blue, green, red, then back to blue; 3 never appears.
  function automatic logic [1:0] ch_step(input logic [1:0] ch);
    logic [1:0] nxt;
    unique case (ch)
      CH_BLUE:  nxt = CH_GREEN;
      CH_GREEN: nxt = CH_RED;
      default:  nxt = CH_BLUE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/k_pixel_sequencer_if.sv
// Enable/select bundle between the pixel sequencer (master) and the K_DSP
// datapath: write-data memory, input FIFO, ALU, output FIFO, read-data memory.
interface k_pixel_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int BANK_W = 2
);
  logic              wmem_read_enable;
  logic [ADDR_W-1:0] wmem_read_address;
  logic [BANK_W-1:0] wmem_bank;
  logic              ififo_write_enable;
  logic              ififo_read_enable;
  logic              ififo_full;
  logic              ififo_empty;
  logic [1:0]        sel;
  logic              alu_enable;
  logic              alu_write_enable;
  logic              ofifo_write_enable;
  logic              ofifo_read_enable;
  logic              ofifo_full;
  logic              ofifo_empty;
  logic              rmem_write_enable;
  logic [ADDR_W-1:0] rmem_address;
  logic [BANK_W-1:0] rmem_bank;

  modport master (
    output wmem_read_enable, wmem_read_address, wmem_bank,
    output ififo_write_enable, ififo_read_enable,
    input  ififo_full, ififo_empty,
    output sel, alu_enable, alu_write_enable,
    output ofifo_write_enable, ofifo_read_enable,
    input  ofifo_full, ofifo_empty,
    output rmem_write_enable, rmem_address, rmem_bank
  );

  modport slave (
    input  wmem_read_enable, wmem_read_address, wmem_bank,
    input  ififo_write_enable, ififo_read_enable,
    output ififo_full, ififo_empty,
    input  sel, alu_enable, alu_write_enable,
    input  ofifo_write_enable, ofifo_read_enable,
    output ofifo_full, ofifo_empty,
    input  rmem_write_enable, rmem_address, rmem_bank
  );
endinterface

// File: rtl/k_pixseq_addr_gen.sv
// Sample index / channel counters plus source and destination address
// generation (src_base+i and dst_base+3*i+ch, wrapping at 2^ADDR_W).
module k_pixseq_addr_gen
  import k_dsp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic              i_ch_step,
  input  logic              i_idx_inc,
  output logic [CNT_W:0]    o_idx,
  output logic [1:0]        o_ch,
  output logic [ADDR_W-1:0] o_src_addr,
  output logic [ADDR_W-1:0] o_dst_addr
);
  localparam int AW2 = ADDR_W + 2;

  logic [CNT_W:0]    r_idx;
  logic [1:0]        r_ch;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
      r_ch  <= CH_BLUE;
      r_src <= '0;
      r_dst <= '0;
    end else if (i_load) begin
      r_idx <= '0;
      r_ch  <= CH_BLUE;
      r_src <= i_src_base;
      r_dst <= i_dst_base;
    end else begin
      if (i_ch_step) r_ch <= ch_step(r_ch);
      if (i_idx_inc) r_idx <= r_idx + (CNT_W+1)'(1);
    end
  end

  // Sums are formed two bits wider than the address, then truncated so they wrap.
  assign o_src_addr = ADDR_W'(AW2'(r_src) + AW2'(r_idx));
  assign o_dst_addr = ADDR_W'(AW2'(r_dst) + AW2'(r_idx) * AW2'(SAMPLES_PER_PIXEL)
                              + AW2'(r_ch));
  assign o_idx      = r_idx;
  assign o_ch       = r_ch;

endmodule

// File: rtl/k_pixel_sequencer.sv
// Pixel sequencer: per sample, fetch -> input FIFO -> ALU over B/G/R -> drain to
// read-data memory. Define K_PIXSEQ_PERF_EN to add perf_cycles/perf_stalls counters.
module k_pixel_sequencer
  import k_dsp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int BANK_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  count,
  input  logic [BANK_W-1:0] bank,
  output logic              busy,
  output logic              done,
`ifdef K_PIXSEQ_PERF_EN
  output logic [31:0]       perf_cycles,
  output logic [15:0]       perf_stalls,
`endif
  k_pixel_sequencer_if.master dp
);
  pixseq_state_t     r_state;
  pixseq_state_t     w_next;
  logic [CNT_W-1:0]  r_count;
  logic [BANK_W-1:0] r_bank;
  logic              w_accept;
  logic              w_ch_step;
  logic              w_idx_inc;
  logic [CNT_W:0]    w_idx;
  logic [1:0]        w_ch;
  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_dst_addr;

  assign w_accept = (r_state == ST_IDLE) && start;

  k_pixseq_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_src_base (src_base),
    .i_dst_base (dst_base),
    .i_ch_step  (w_ch_step),
    .i_idx_inc  (w_idx_inc),
    .o_idx      (w_idx),
    .o_ch       (w_ch),
    .o_src_addr (w_src_addr),
    .o_dst_addr (w_dst_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_bank  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_count <= count;
        r_bank  <= bank;
      end
    end
  end

  assign dp.wmem_bank = r_bank;
  assign dp.rmem_bank = r_bank;

  // Outputs decode the registered state; only the FIFO full/empty flags gate them.
  always_comb begin
    w_next                = r_state;
    w_ch_step             = 1'b0;
    w_idx_inc             = 1'b0;
    busy                  = 1'b0;
    done                  = 1'b0;
    dp.wmem_read_enable   = 1'b0;
    dp.wmem_read_address  = '0;
    dp.ififo_write_enable = 1'b0;
    dp.ififo_read_enable  = 1'b0;
    dp.sel                = CH_BLUE;
    dp.alu_enable         = 1'b0;
    dp.alu_write_enable   = 1'b0;
    dp.ofifo_write_enable = 1'b0;
    dp.ofifo_read_enable  = 1'b0;
    dp.rmem_write_enable  = 1'b0;
    dp.rmem_address       = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = (count == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        busy                 = 1'b1;
        dp.wmem_read_enable  = 1'b1;
        dp.wmem_read_address = w_src_addr;
        w_next               = ST_LOAD;
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (!dp.ififo_full) begin
          dp.ififo_write_enable = 1'b1;
          w_next                = ST_POP;
        end
      end
      ST_POP: begin
        busy = 1'b1;
        if (!dp.ififo_empty) begin
          dp.ififo_read_enable = 1'b1;
          w_next               = ST_ALU;
        end
      end
      ST_ALU: begin
        busy          = 1'b1;
        dp.sel        = w_ch;
        dp.alu_enable = 1'b1;
        if (!dp.ofifo_full) begin
          dp.alu_write_enable   = 1'b1;
          dp.ofifo_write_enable = 1'b1;
          w_ch_step             = 1'b1;
          if (w_ch == CH_RED) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy            = 1'b1;
        dp.rmem_address = w_dst_addr;
        if (!dp.ofifo_empty) begin
          dp.ofifo_read_enable = 1'b1;
          dp.rmem_write_enable = 1'b1;
          w_ch_step            = 1'b1;
          if (w_ch == CH_RED) w_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        busy      = 1'b1;
        w_idx_inc = 1'b1;
        w_next    = ((w_idx + (CNT_W+1)'(1)) == {1'b0, r_count}) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef K_PIXSEQ_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [15:0] r_perf_stalls;
  logic        w_stall;

  assign w_stall = ((r_state == ST_LOAD)  && dp.ififo_full)  ||
                   ((r_state == ST_POP)   && dp.ififo_empty) ||
                   ((r_state == ST_ALU)   && dp.ofifo_full)  ||
                   ((r_state == ST_DRAIN) && dp.ofifo_empty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if (w_accept) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (busy) r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_stall && (r_perf_stalls != '1)) r_perf_stalls <= r_perf_stalls + 16'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule
